// File: rtl/accum_pkg.sv
// Shared definitions for the sample accumulator.
// Holds the accumulator FSM state encoding and the sample data width.
package accum_pkg;

    localparam int DATA_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } accum_state_t;

endpackage : accum_pkg

// File: rtl/adder_16bit.sv
// 16-bit unsigned adder with carry-in.
// Ports:
//   a, b      : operands
//   carry_in  : carry into bit 0
//   sum       : a + b + carry_in, modulo 2^16
//   overflow  : carry out of bit 15
module adder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        carry_in,
    output logic [15:0] sum,
    output logic        overflow
);

    logic [16:0] full_sum_s;

    // Widen to 17 bits so the carry out of bit 15 is captured.
    always_comb begin
        full_sum_s = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};
        sum        = full_sum_s[15:0];
        overflow   = full_sum_s[16];
    end

endmodule : adder_16bit

// File: rtl/sample_accumulator.sv
// Sums NUM_SAMPLES 16-bit unsigned samples (modulo 2^16) taken over a
// valid/ready handshake and holds the sum until the consumer acknowledges.
// Ports:
//   clk, n_rst    : clock (rising edge), async active-low reset
//   clear         : synchronous abort back to IDLE, discards any sample
//   data_in/valid : sample stream; data_ready is high in IDLE/ACCUM
//   result        : running/final sum, valid while result_valid
//   result_ack    : consumer takes result (only honoured in DONE)
//   overflow_flag : sticky carry-out of any addition this accumulation
//   sample_count  : samples accepted in the current accumulation
module sample_accumulator
    import accum_pkg::*;
#(
    parameter int NUM_SAMPLES = 8,
    parameter int CNT_WIDTH   = $clog2(NUM_SAMPLES + 1)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    input  logic                  result_ack,
    output logic                  overflow_flag,
    output logic [CNT_WIDTH-1:0]  sample_count
);

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_SAMPLES);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT  = CNT_WIDTH'(1);

    accum_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  ovf_q, ovf_d;

    logic [DATA_WIDTH-1:0] add_sum_s;
    logic                  add_ovf_s;
    logic                  accept_s;
    logic [CNT_WIDTH-1:0]  count_inc_s;

    adder_16bit u_adder (
        .a        (acc_q),
        .b        (data_in),
        .carry_in (1'b0),
        .sum      (add_sum_s),
        .overflow (add_ovf_s)
    );

    // Output decodes; ready depends only on state so it never loops back
    // through data_valid.
    always_comb begin
        data_ready    = (state_q != DONE);
        result_valid  = (state_q == DONE);
        result        = acc_q;
        overflow_flag = ovf_q;
        sample_count  = count_q;
        accept_s      = data_valid && data_ready;
        count_inc_s   = count_q + ONE_CNT;
    end

    // Next-state and datapath update; clear overrides every state.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = 16'd0;
            count_d = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept_s) begin
                        acc_d   = add_sum_s;
                        ovf_d   = ovf_q | add_ovf_s;
                        count_d = count_inc_s;
                        if (count_inc_s == LAST_CNT) begin
                            state_d = DONE;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                DONE: begin
                    if (result_ack) begin
                        state_d = IDLE;
                        acc_d   = 16'd0;
                        count_d = '0;
                        ovf_d   = 1'b0;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    acc_d   = 16'd0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            acc_q   <= 16'd0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule : sample_accumulator

// File: doc/sample_accumulator.md
# sample_accumulator

Sequential accumulator that sits directly upstream of the result path and drives the existing `adder_16bit` as its datapath. It accepts a stream of 16-bit unsigned samples over a valid/ready handshake and sums a fixed number of them modulo 2^16 using `adder_16bit`. It then presents the sum with a sticky overflow flag until the consumer acknowledges it.

## Interface
Parameters:
- `NUM_SAMPLES`, default 8: samples per accumulation. Legal range is 1..65535.
- `CNT_WIDTH`, default `$clog2(NUM_SAMPLES+1)`: width of `sample_count`.

Ports:
- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `clear` in 1: synchronous abort, highest priority after reset.
- `data_in` in 16: sample value.
- `data_valid` in 1: `data_in` is valid this cycle.
- `data_ready` out 1: block can accept a sample this cycle.
- `result` out 16: accumulated sum. Valid while `result_valid`=1.
- `result_valid` out 1: accumulation complete.
- `result_ack` in 1: consumer has taken `result`.
- `overflow_flag` out 1: sticky. Set if any addition in the current accumulation carried out of bit 15.
- `sample_count` out `CNT_WIDTH`: samples accepted in the current accumulation.

## Operation
- Accept condition: a sample is accepted when `data_valid` && `data_ready`.
- Datapath: one `adder_16bit` instance with `a`=`acc`, `b`=`data_in`, `carry_in`=0. On accept, `acc` <= `sum` and `overflow_flag` <= `overflow_flag` | `overflow`. Sums wrap modulo 2^16.
- `result` is driven directly from `acc`.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - `acc`=0, `count`=0, `data_ready`=1.
  - On accept: go to DONE if `NUM_SAMPLES`=1, else go to ACCUM.
- ACCUM:
  - `data_ready`=1.
  - On accept, increment `count`.
  - Go to DONE on the accept that makes `count`=`NUM_SAMPLES`.
- DONE:
  - `data_ready`=0, `result_valid`=1. `result`, `overflow_flag` and `sample_count` are held.
  - On `result_ack`: go to IDLE, zero `acc`, `count` and `overflow_flag`.
  - `result_ack` outside DONE is ignored.
- `clear`=1 in any state:
  - Next state IDLE; `acc`, `count` and `overflow_flag` are zeroed.
  - A sample offered in the same cycle is discarded, even though `data_ready`=1.
- Reset (`n_rst`=0, any time, including mid-accumulation):
  - State IDLE; `acc`, `count` and `overflow_flag` = 0.
  - Output values during reset: `result`=0, `result_valid`=0, `data_ready`=1, `sample_count`=0.

## Timing
- All state updates occur on the rising `clk` edge. Reset is asynchronous assert, released synchronously by the environment.
- Throughput is one sample per cycle in IDLE/ACCUM.
- `result_valid` rises the cycle after the final accept (latency 1). `result` is stable that same cycle.
- Minimum DONE dwell is 1 cycle, when `result_ack` is high on the first DONE cycle. `data_ready` returns to 1 the cycle after the ack.
- Back-to-back: in DONE, `data_ready`=0, so a sample presented together with `result_ack` is not accepted. It is accepted in the following IDLE cycle if still valid.
- Outputs are registered or pure decodes of state/registers. `data_ready` does not depend combinationally on `data_valid`.

## Structure
- Shared package `accum_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, ACCUM, DONE} accum_state_t`
  - `localparam DATA_WIDTH = 16`
- Sub-module: reuse the existing `adder_16bit` (ports `a`, `b`, `carry_in`, `sum`, `overflow`) unchanged. No other hierarchy.
- The FSM and registers live in `sample_accumulator`.

## Test plan
- Reset then feed 8 samples of 16'd1000, one per cycle, with `NUM_SAMPLES`=8. Required: `result_valid` high 1 cycle after the 8th accept, `result`=16'd8000, `overflow_flag`=0, `sample_count`=8.
- Feed 8 samples of 16'hFFFF. Required: `result`=16'hFFF8, `overflow_flag`=1, held until ack, then `overflow_flag`=0 in IDLE.
- Toggle `data_valid` randomly over 200 cycles with random data. Required: `result` equals the reference sum mod 2^16 of exactly the accepted samples, and no accept occurs while `result_valid`=1.
- Hold `result_ack`=0 for 5 cycles in DONE while `data_valid`=1 with `data_in`=16'h1234. Required: outputs unchanged and `data_ready`=0. Assert `result_ack`: IDLE next cycle, then 16'h1234 is accepted as sample 1.
- Assert `clear` after 3 samples of 16'd5, in the same cycle as a 4th sample. Required: next cycle `sample_count`=0 with the 4th sample discarded. A fresh 8 samples of 16'd2 then give `result`=16'd16.
- Drop `n_rst` mid-accumulation, after 4 samples. Required: immediate `result_valid`=0, `sample_count`=0, `data_ready`=1. With `NUM_SAMPLES`=1, a single sample 16'd7 gives `result`=16'd7 one cycle later.
